// File: rtl/dvp_pkg.sv
// Shared types and timing helpers for the DVP camera-side transmitter.
package dvp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSYNC,
    ST_VBACK,
    ST_ACTIVE,
    ST_VFRONT
  } dvp_state_t;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_BLANK  = 160;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_VS_LINES = 4;
  localparam int unsigned DEF_V_BACK   = 20;
  localparam int unsigned DEF_V_FRONT  = 10;

  function automatic int unsigned line_slots(input int unsigned h_active,
                                             input int unsigned h_blank);
    return 2 * h_active + h_blank;
  endfunction

  function automatic int unsigned frame_slots(input int unsigned h_active,
                                              input int unsigned h_blank,
                                              input int unsigned vs_lines,
                                              input int unsigned v_back,
                                              input int unsigned v_active,
                                              input int unsigned v_front);
    return line_slots(h_active, h_blank) * (vs_lines + v_back + v_active + v_front);
  endfunction

endpackage

// File: rtl/dvp_tx_timing.sv
// Slot/line counters and frame FSM; outputs are registered on the update
// edge (phase 1->0) from the position the next slot will occupy.
module dvp_tx_timing
  import dvp_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_BLANK  = DEF_H_BLANK,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned VS_LINES = DEF_VS_LINES,
  parameter int unsigned V_BACK   = DEF_V_BACK,
  parameter int unsigned V_FRONT  = DEF_V_FRONT
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic s_valid,
  input  logic s_sof,
  output logic pclk,
  output logic update,
  output logic take,
  output logic byte_sel,
  output logic first_pixel,
  output logic idle,
  output logic href,
  output logic vsync,
  output logic frame_end
);

  localparam int unsigned L     = line_slots(H_ACTIVE, H_BLANK);
  localparam int unsigned VM_A  = (VS_LINES > V_BACK) ? VS_LINES : V_BACK;
  localparam int unsigned VM_B  = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
  localparam int unsigned V_MAX = (VM_A > VM_B) ? VM_A : VM_B;
  localparam int unsigned SW    = (L > 1) ? $clog2(L) : 1;
  localparam int unsigned LW    = (V_MAX > 1) ? $clog2(V_MAX) : 1;

  localparam logic [SW-1:0] SLOT_LAST = SW'(L - 1);
  localparam logic [SW:0]   HREF_END  = (SW + 1)'(2 * H_ACTIVE);

  dvp_state_t    state, nstate;
  logic          phase;
  logic [SW-1:0] slot, nslot;
  logic [LW-1:0] line, nline, line_last;
  logic          start, fend, nhref;

  always_comb begin
    start     = enable && s_valid && s_sof;
    nstate    = state;
    nslot     = slot;
    nline     = line;
    fend      = 1'b0;
    line_last = '0;
    case (state)
      ST_VSYNC:  line_last = LW'(VS_LINES - 1);
      ST_VBACK:  line_last = LW'(V_BACK - 1);
      ST_ACTIVE: line_last = LW'(V_ACTIVE - 1);
      ST_VFRONT: line_last = LW'(V_FRONT - 1);
      default:   line_last = '0;
    endcase

    if (state == ST_IDLE) begin
      if (start) nstate = ST_VSYNC;
    end else if (slot == SLOT_LAST) begin
      nslot = '0;
      if (line == line_last) begin
        nline = '0;
        case (state)
          ST_VSYNC:  nstate = ST_VBACK;
          ST_VBACK:  nstate = ST_ACTIVE;
          ST_ACTIVE: nstate = ST_VFRONT;
          default: begin
            fend   = 1'b1;
            nstate = start ? ST_VSYNC : ST_IDLE;
          end
        endcase
      end else begin
        nline = line + LW'(1);
      end
    end else begin
      nslot = slot + SW'(1);
    end

    // Pixel requests are made in the cycle before the slot they fill.
    nhref       = (nstate == ST_ACTIVE) && ({1'b0, nslot} < HREF_END);
    take        = phase && nhref && !nslot[0];
    byte_sel    = phase && nhref && nslot[0];
    first_pixel = take && (nslot == '0) && (nline == '0);
  end

  assign pclk   = phase;
  assign update = phase;
  assign idle   = (state == ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase     <= 1'b0;
      state     <= ST_IDLE;
      slot      <= '0;
      line      <= '0;
      href      <= 1'b0;
      vsync     <= 1'b0;
      frame_end <= 1'b0;
    end else begin
      phase     <= !phase;
      frame_end <= 1'b0;
      if (phase) begin
        state     <= nstate;
        slot      <= nslot;
        line      <= nline;
        href      <= nhref;
        vsync     <= (nstate == ST_VSYNC);
        frame_end <= fend;
      end
    end
  end

endmodule

// File: rtl/dvp_tx.sv
// DVP transmitter: RGB565 stream in, two bytes per pixel out (high first),
// with sticky underflow / misplaced-SOF flags.
module dvp_tx
  import dvp_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_BLANK  = DEF_H_BLANK,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned VS_LINES = DEF_VS_LINES,
  parameter int unsigned V_BACK   = DEF_V_BACK,
  parameter int unsigned V_FRONT  = DEF_V_FRONT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [15:0] s_data,
  input  logic        s_valid,
  input  logic        s_sof,
  output logic        s_ready,
  output logic        dvp_pclk,
  output logic        dvp_vsync,
  output logic        dvp_href,
  output logic [7:0]  dvp_db,
  output logic        frame_done,
  output logic        underflow,
  output logic        sof_err,
  input  logic        clr_err
);

  logic       update, take, byte_sel, first_pixel, idle;
  logic [7:0] lo_byte;

  dvp_tx_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_BLANK  (H_BLANK),
    .V_ACTIVE (V_ACTIVE),
    .VS_LINES (VS_LINES),
    .V_BACK   (V_BACK),
    .V_FRONT  (V_FRONT)
  ) u_timing (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .s_valid     (s_valid),
    .s_sof       (s_sof),
    .pclk        (dvp_pclk),
    .update      (update),
    .take        (take),
    .byte_sel    (byte_sel),
    .first_pixel (first_pixel),
    .idle        (idle),
    .href        (dvp_href),
    .vsync       (dvp_vsync),
    .frame_end   (frame_done)
  );

  // In IDLE, stray non-SOF pixels are drained; the SOF pixel is held.
  assign s_ready = idle ? (s_valid && !s_sof) : take;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvp_db    <= '0;
      lo_byte   <= '0;
      underflow <= 1'b0;
      sof_err   <= 1'b0;
    end else begin
      if (update) begin
        if (take) begin
          dvp_db  <= s_valid ? s_data[15:8] : '0;
          lo_byte <= s_valid ? s_data[7:0]  : '0;
        end else if (byte_sel) begin
          dvp_db  <= lo_byte;
        end else begin
          dvp_db  <= '0;
        end
      end
      underflow <= (take && !s_valid) || (underflow && !clr_err);
      sof_err   <= (take && s_valid && s_sof && !first_pixel) || (sof_err && !clr_err);
    end
  end

endmodule

// File: tb/tb_dvp_tx.sv
// Scoreboard bench for dvp_tx with a small 4x2 frame geometry.
module tb_dvp_tx;
  import dvp_pkg::*;

  localparam int unsigned HA = 4, HB = 2, VA = 2, VS = 1, VB = 1, VF = 1;
  localparam int unsigned LSL       = line_slots(HA, HB);
  localparam int unsigned FRAME_CLK = 2 * frame_slots(HA, HB, VS, VB, VA, VF);
  localparam int unsigned VS_CLK    = 2 * VS * LSL;
  localparam int unsigned HREF_CLK  = 4 * HA;

  logic        clk = 1'b0, rst = 1'b1, enable = 1'b1;
  logic [15:0] s_data = '0;
  logic        s_valid = 1'b0, s_sof = 1'b0, clr_err = 1'b0;
  logic        s_ready, dvp_pclk, dvp_vsync, dvp_href, frame_done, underflow, sof_err;
  logic [7:0]  dvp_db;

  int n_vec = 0, n_err = 0;
  logic [7:0] exp_q[$];

  dvp_tx #(
    .H_ACTIVE (HA), .H_BLANK (HB), .V_ACTIVE (VA),
    .VS_LINES (VS), .V_BACK (VB), .V_FRONT (VF)
  ) dut (
    .clk (clk), .rst (rst), .enable (enable),
    .s_data (s_data), .s_valid (s_valid), .s_sof (s_sof), .s_ready (s_ready),
    .dvp_pclk (dvp_pclk), .dvp_vsync (dvp_vsync), .dvp_href (dvp_href), .dvp_db (dvp_db),
    .frame_done (frame_done), .underflow (underflow), .sof_err (sof_err), .clr_err (clr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // Presents one pixel and waits for the handshake; a pixel with valid=0
  // waits for the slot it should have filled and expects zero bytes.
  task automatic send(input logic [15:0] d, input logic sof, input logic valid,
                      input logic expect_out, input logic clr);
    int n;
    @(negedge clk);
    s_data = d; s_sof = sof; s_valid = valid; clr_err = clr;
    n = 0;
    #1;
    while (!s_ready && n < 1000) begin
      @(negedge clk); #1; n++;
    end
    if (!s_ready) fail_timeout("accept");
    else if (expect_out) begin
      exp_q.push_back(valid ? d[15:8] : 8'h00);
      exp_q.push_back(valid ? d[7:0]  : 8'h00);
    end
    @(posedge clk); #1;
    s_valid = 1'b0; s_sof = 1'b0; clr_err = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] seed, input int gap_idx,
                            input int sof2_idx, input logic clr_at_sof2);
    for (int i = 0; i < int'(HA * VA); i++) begin
      logic [15:0] d;
      d = seed + 16'(i * 'h2222);
      send(d, (i == 0) || (i == sof2_idx), i != gap_idx, 1'b1, (i == sof2_idx) && clr_at_sof2);
    end
  endtask

  task automatic wait_frame_done();
    int n;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!frame_done && n < 400);
    if (frame_done) chk("frame_done", frame_done, 1);
    else fail_timeout("frame_done");
  endtask

  task automatic pulse_clr();
    @(negedge clk); clr_err = 1'b1;
    @(negedge clk); clr_err = 1'b0;
    #1;
  endtask

  // Monitor: one byte per pclk rise; also checks vsync/href/frame lengths.
  initial begin
    int vs_cnt, hr_cnt, fr_cnt;
    logic armed, prev_vs, prev_hr;
    logic [7:0] e;
    vs_cnt = 0; hr_cnt = 0; fr_cnt = 0; armed = 0; prev_vs = 0; prev_hr = 0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        vs_cnt = 0; hr_cnt = 0; fr_cnt = 0; armed = 0; prev_vs = 0; prev_hr = 0;
      end else begin
        if (dvp_pclk) begin
          if (dvp_href) begin
            if (exp_q.size() == 0) begin
              n_vec++; n_err++;
              $display("FAIL unexpected_byte: got %0h, expected none at %0t", dvp_db, $time);
            end else begin
              e = exp_q.pop_front();
              chk("db", dvp_db, e);
            end
          end else begin
            chk("db_blank_zero", dvp_db, 0);
          end
        end
        fr_cnt++;
        if (frame_done) begin
          if (armed) chk("frame_len", fr_cnt, FRAME_CLK);
          armed = 0;
        end
        if (dvp_vsync && !prev_vs) begin armed = 1; fr_cnt = 0; end
        if (dvp_vsync) vs_cnt++;
        else if (prev_vs) begin chk("vsync_len", vs_cnt, VS_CLK); vs_cnt = 0; end
        if (dvp_href) hr_cnt++;
        else if (prev_hr) begin chk("href_len", hr_cnt, HREF_CLK); hr_cnt = 0; end
        prev_vs = dvp_vsync;
        prev_hr = dvp_href;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic vs_seen, rdy_seen;
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pclk", dvp_pclk, 0);
    chk("rst_vsync", dvp_vsync, 0);
    chk("rst_href", dvp_href, 0);
    chk("rst_db", dvp_db, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_flags", {underflow, sof_err}, 0);
    @(negedge clk); rst = 1'b0;

    // Clean frame: 0x1122, 0x3344, ...
    send_frame(16'h1122, -1, -1, 1'b0);
    wait_frame_done();
    chk("clean_underflow", underflow, 0);
    chk("clean_sof_err", sof_err, 0);

    // Underflow on the 3rd pixel of line 0
    send_frame(16'h0a0b, 2, -1, 1'b0);
    wait_frame_done();
    chk("underflow_set", underflow, 1);
    chk("underflow_no_sof_err", sof_err, 0);
    pulse_clr();
    chk("underflow_cleared", underflow, 0);

    // SOF on pixel 5 with clr_err asserted during that accept: set wins
    send_frame(16'h4455, -1, 5, 1'b1);
    wait_frame_done();
    chk("sof_err_set", sof_err, 1);
    chk("sof_err_no_underflow", underflow, 0);
    pulse_clr();
    chk("sof_err_cleared", sof_err, 0);

    // Flush of non-SOF pixels in IDLE
    send(16'hdead, 1'b0, 1'b1, 1'b0, 1'b0);
    send(16'hbeef, 1'b0, 1'b1, 1'b0, 1'b0);
    send(16'hcafe, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("flush_vsync_low", dvp_vsync, 0);
    send_frame(16'h6677, -1, -1, 1'b0);
    wait_frame_done();

    // enable dropped during VBACK: frame completes, then IDLE
    fork
      send_frame(16'h1357, -1, -1, 1'b0);
      begin
        int n;
        logic seen;
        n = 0; seen = 0;
        while (!(seen && !dvp_vsync) && n < 300) begin
          @(posedge clk); #1; n++;
          if (dvp_vsync) seen = 1;
        end
        if (seen && !dvp_vsync) enable = 1'b0;
        else fail_timeout("vback_entry");
      end
    join
    wait_frame_done();
    @(negedge clk);
    s_data = 16'h2468; s_sof = 1'b1; s_valid = 1'b1;
    vs_seen = 0; rdy_seen = 0;
    repeat (60) begin
      @(posedge clk); #1;
      vs_seen |= dvp_vsync;
      rdy_seen |= s_ready;
    end
    chk("disabled_vsync_low", vs_seen, 0);
    chk("disabled_sof_held", rdy_seen, 0);
    @(negedge clk); s_valid = 1'b0; s_sof = 1'b0;
    enable = 1'b1;

    // Asynchronous reset in the middle of ACTIVE
    send(16'h1a1b, 1'b1, 1'b1, 1'b1, 1'b0);
    send(16'h2a2b, 1'b0, 1'b0, 1'b1, 1'b0);
    send(16'h3a3b, 1'b0, 1'b1, 1'b1, 1'b0);
    #1;
    chk("pre_rst_underflow", underflow, 1);
    rst = 1'b1;
    #1;
    chk("arst_outputs", {dvp_pclk, dvp_vsync, dvp_href, frame_done, underflow, sof_err}, 0);
    chk("arst_db", dvp_db, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    vs_seen = 0;
    repeat (30) begin
      @(posedge clk); #1;
      vs_seen |= dvp_vsync;
    end
    chk("post_rst_idle", vs_seen, 0);
    send_frame(16'h5a5b, -1, -1, 1'b0);
    wait_frame_done();
    chk("final_flags", {underflow, sof_err}, 0);
    repeat (4) @(posedge clk);
    #1;
    chk("queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
